ahb_fabric_dp: RTL
==================

# ahb_fabric_dp

Parametrised single-master, N-slave bus fabric datapath with a pipelined address/data phase. It decodes the master address into one-hot slave selects and registers the data-phase owner. It steers read data, ready and response from the owning slave back to the master, and includes a built-in default slave that returns a two-cycle ERROR for unmapped addresses. It sits between the master interface and the slave array, replacing the fixed three-slave datapath, and adds a saturating error counter for debug.

## Interface
- NUM_SLAVES, 3, number of slaves; must be ≤ 2**SEL_W
- ADDR_W, 16, address width
- DATA_W, 32, data width
- SEL_W, 2, upper address bits used for slave index
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- Abus  in  ADDR_W  master address (address phase)
- addr_valid  in  1  master requests a transfer this cycle
- write  in  1  transfer direction, 1 = write
- bus_dout  in  DATA_W  master write data (data phase)
- bus_din  out  DATA_W  read data to master
- rdyout  out  1  transfer-complete / ready to master
- respout  out  2  response to master: 00 OKAY, 01 ERROR, 10 RETRY, 11 SPLIT
- address  out  ADDR_W  address to all slaves (= Abus)
- wr_out  out  1  direction to all slaves (= write)
- dataout  out  DATA_W  write data to all slaves (= bus_dout)
- slave_sel  out  NUM_SLAVES  one-hot address-phase select
- rdin  in  NUM_SLAVES*DATA_W  slave read data, slave k at bits [k*DATA_W +: DATA_W]
- rdy  in  NUM_SLAVES  per-slave ready
- resp  in  NUM_SLAVES*2  per-slave response, slave k at [2k +: 2]
- err_count  out  8  count of completed ERROR responses

## Operation
- Index: idx = Abus[ADDR_W-1 -: SEL_W]. The address is mapped iff idx < NUM_SLAVES.
- slave_sel is combinational. It equals onehot(idx) when addr_valid is high and the address is mapped; otherwise it is all zero.
- Accept: accept = addr_valid & rdyout, sampled at the rising edge.
- Data-phase FSM states:
  - DP_IDLE: rdyout=1, respout=00, bus_din=0.
  - DP_SLAVE: owner dsel is registered. bus_din, rdyout and respout come from slave dsel. The rdy, resp and rdin of every other slave are ignored.
  - DP_ERR1: rdyout=0, respout=01, bus_din=0.
  - DP_ERR2: rdyout=1, respout=01, bus_din=0.
- Transitions from any state with rdyout=1 (IDLE, SLAVE with rdy[dsel]=1, ERR2):
  - accept & mapped → DP_SLAVE, dsel<=idx.
  - accept & unmapped → DP_ERR1.
  - otherwise → DP_IDLE.
- DP_SLAVE with rdy[dsel]=0 stays in DP_SLAVE; no new address is accepted.
- DP_ERR1 → DP_ERR2 unconditionally.
- err_count increments by 1 on each edge where rdyout=1 and respout=01. This covers both slave and default-slave errors. The counter saturates at 255.
- Reset values: state DP_IDLE, dsel=0, err_count=0, rdyout=1, respout=00, bus_din=0. Passthrough outputs and slave_sel follow their inputs.

## Timing
- Latency: the data phase occurs in the cycle after acceptance. Zero-wait slave read data appears on bus_din in that cycle.
- Back-to-back transfers are fully pipelined. The next address phase overlaps the current data phase, with one transfer per cycle at zero wait.
- Wait states: each cycle with rdy[dsel]=0 stretches the data phase by one cycle. The master must hold Abus and addr_valid stable during this time.
- Unmapped access completes in exactly 2 data-phase cycles. An address presented during DP_ERR1 is not accepted. An address presented during DP_ERR2 is accepted normally. A master may also drop addr_valid during DP_ERR1 to cancel.
- Reset asserted mid-transfer returns the block to DP_IDLE immediately, independent of clk. The in-flight transfer is abandoned.
- RETRY and SPLIT from a slave are passed through unmodified and are not counted.

## Structure
- Package ahb_fabric_pkg holds:
  - response constants RESP_OKAY, RESP_ERROR, RESP_RETRY, RESP_SPLIT;
  - the dp_state_t enum (DP_IDLE, DP_SLAVE, DP_ERR1, DP_ERR2).
- Sub-module ahb_addr_decoder (parameters NUM_SLAVES, ADDR_W, SEL_W; outputs one-hot select, idx, mapped), instantiated once.
- Read-data/response steering is an indexed part-select on dsel inside the top module.

## Test plan
- Reset: pulse rst mid-cycle → rdyout=1, respout=00, bus_din=0, err_count=0, slave_sel=000 with addr_valid=0.
- Read 0x4010, addr_valid=1; next cycle rdin1=0xDEADBEEF, rdy1=1 → slave_sel=010 in the address cycle, then bus_din=0xDEADBEEF, rdyout=1, respout=00.
- Slave 2 read (0x8000) with rdy2=0 for 3 cycles, next address 0x0004 held → rdyout low 3 cycles; 0x0004 accepted on the 4th data-phase cycle; slave 0 becomes owner next.
- Unmapped 0xC000 → DP_ERR1 (rdyout=0, respout=01), then DP_ERR2 (rdyout=1, respout=01); err_count=1. Repeat 300× → err_count=255.
- Back-to-back 0x0000, 0x8000, 0x4000 zero-wait, with distinct rdin values per slave → bus_din shows slave 0, 2, 1 data on consecutive cycles.
- rst asserted during DP_ERR1 → immediate rdyout=1, respout=00, err_count=0. With NUM_SLAVES=4, 0xC000 selects slave 3 with no error.

Source files
------------

// File: rtl/ahb_fabric_pkg.sv
// ahb_fabric_pkg
// Shared definitions for the single-master AHB fabric datapath:
//   - RESP_* : two-bit bus response encodings returned to the master
//   - dp_state_t : data-phase state of the fabric
package ahb_fabric_pkg;

    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [1:0] RESP_ERROR = 2'b01;
    localparam logic [1:0] RESP_RETRY = 2'b10;
    localparam logic [1:0] RESP_SPLIT = 2'b11;

    typedef enum logic [1:0] {
        DP_IDLE  = 2'd0,
        DP_SLAVE = 2'd1,
        DP_ERR1  = 2'd2,
        DP_ERR2  = 2'd3
    } dp_state_t;

endpackage : ahb_fabric_pkg

// File: rtl/ahb_addr_decoder.sv
// ahb_addr_decoder
// Combinational address decoder. The top SEL_W address bits form the
// slave index; indices at or above NUM_SLAVES are unmapped and fall to the
// fabric's built-in default slave.
// Ports:
//   addr   in  ADDR_W      master address
//   valid  in  1           master requests a transfer
//   sel    out NUM_SLAVES  one-hot slave select (zero when idle or unmapped)
//   idx    out SEL_W       raw slave index from the address
//   mapped out 1           index addresses a real slave
module ahb_addr_decoder
    import ahb_fabric_pkg::*;
#(
    parameter int NUM_SLAVES = 3,
    parameter int ADDR_W     = 16,
    parameter int SEL_W      = 2
) (
    input  logic [ADDR_W-1:0]     addr,
    input  logic                  valid,
    output logic [NUM_SLAVES-1:0] sel,
    output logic [SEL_W-1:0]      idx,
    output logic                  mapped
);

    logic [SEL_W-1:0] idx_s;
    logic             mapped_s;

    assign idx_s    = addr[ADDR_W-1 -: SEL_W];
    assign mapped_s = (32'(idx_s) < NUM_SLAVES);
    assign idx      = idx_s;
    assign mapped   = mapped_s;

    // One-hot select; only asserted for a valid, mapped request
    always_comb begin
        sel = '0;
        for (int k = 0; k < NUM_SLAVES; k++) begin
            if (valid && mapped_s && (32'(idx_s) == k)) begin
                sel[k] = 1'b1;
            end else begin
                sel[k] = 1'b0;
            end
        end
    end

endmodule : ahb_addr_decoder

// File: rtl/ahb_fabric_dp.sv
// ahb_fabric_dp
// Single-master, N-slave bus fabric datapath with pipelined address and data
// phases. The address phase decodes a one-hot slave select; the accepted
// owner is registered and, during the data phase, its read data, ready and
// response are steered back to the master. Unmapped addresses go to an
// internal default slave that answers with a two-cycle ERROR. A saturating
// counter tallies completed ERROR responses for debug.
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   Abus, addr_valid, write master address phase
//   bus_dout               master write data (data phase)
//   bus_din, rdyout, respout  read data / ready / response to master
//   address, wr_out, dataout  broadcast to every slave
//   slave_sel              one-hot address-phase select
//   rdin, rdy, resp        packed per-slave read data / ready / response
//   err_count              saturating count of completed ERROR responses
module ahb_fabric_dp
    import ahb_fabric_pkg::*;
#(
    parameter int NUM_SLAVES = 3,
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 32,
    parameter int SEL_W      = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [ADDR_W-1:0]            Abus,
    input  logic                         addr_valid,
    input  logic                         write,
    input  logic [DATA_W-1:0]            bus_dout,
    output logic [DATA_W-1:0]            bus_din,
    output logic                         rdyout,
    output logic [1:0]                   respout,
    output logic [ADDR_W-1:0]            address,
    output logic                         wr_out,
    output logic [DATA_W-1:0]            dataout,
    output logic [NUM_SLAVES-1:0]        slave_sel,
    input  logic [NUM_SLAVES*DATA_W-1:0] rdin,
    input  logic [NUM_SLAVES-1:0]        rdy,
    input  logic [NUM_SLAVES*2-1:0]      resp,
    output logic [7:0]                   err_count
);

    dp_state_t        state_r, state_nxt_s;
    logic [SEL_W-1:0] dsel_r, dsel_nxt_s;
    logic [7:0]       err_count_r;

    logic [SEL_W-1:0] idx_s;
    logic             mapped_s;
    logic             accept_s;
    logic [DATA_W-1:0] bus_din_s;
    logic             rdyout_s;
    logic [1:0]       respout_s;

    ahb_addr_decoder #(
        .NUM_SLAVES (NUM_SLAVES),
        .ADDR_W     (ADDR_W),
        .SEL_W      (SEL_W)
    ) u_dec (
        .addr   (Abus),
        .valid  (addr_valid),
        .sel    (slave_sel),
        .idx    (idx_s),
        .mapped (mapped_s)
    );

    // Slaves see the master's address phase and write data unchanged
    assign address = Abus;
    assign wr_out  = write;
    assign dataout = bus_dout;

    // A new address is only taken while the current data phase completes
    assign accept_s = addr_valid & rdyout_s;

    // Data-phase return path: owning slave in DP_SLAVE, default slave otherwise
    always_comb begin
        bus_din_s = '0;
        rdyout_s  = 1'b1;
        respout_s = RESP_OKAY;
        case (state_r)
            DP_IDLE: begin
                bus_din_s = '0;
                rdyout_s  = 1'b1;
                respout_s = RESP_OKAY;
            end
            DP_SLAVE: begin
                bus_din_s = rdin[int'(dsel_r)*DATA_W +: DATA_W];
                rdyout_s  = rdy[int'(dsel_r) +: 1];
                respout_s = resp[2*int'(dsel_r) +: 2];
            end
            DP_ERR1: begin
                bus_din_s = '0;
                rdyout_s  = 1'b0;
                respout_s = RESP_ERROR;
            end
            DP_ERR2: begin
                bus_din_s = '0;
                rdyout_s  = 1'b1;
                respout_s = RESP_ERROR;
            end
            default: begin
                bus_din_s = '0;
                rdyout_s  = 1'b1;
                respout_s = RESP_OKAY;
            end
        endcase
    end

    assign bus_din   = bus_din_s;
    assign rdyout    = rdyout_s;
    assign respout   = respout_s;
    assign err_count = err_count_r;

    // Next-state and owner selection
    always_comb begin
        state_nxt_s = state_r;
        dsel_nxt_s  = dsel_r;
        if (state_r == DP_ERR1) begin
            state_nxt_s = DP_ERR2;
        end else if (!rdyout_s) begin
            // Slave is inserting wait states: hold owner and state
            state_nxt_s = state_r;
        end else if (accept_s && mapped_s) begin
            state_nxt_s = DP_SLAVE;
            dsel_nxt_s  = idx_s;
        end else if (accept_s) begin
            state_nxt_s = DP_ERR1;
        end else begin
            state_nxt_s = DP_IDLE;
        end
    end

    // State and data-phase owner registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= DP_IDLE;
            dsel_r  <= '0;
        end else begin
            state_r <= state_nxt_s;
            dsel_r  <= dsel_nxt_s;
        end
    end

    // Saturating count of completed ERROR responses (slave or default slave)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_count_r <= 8'd0;
        end else if (rdyout_s && (respout_s == RESP_ERROR) && (err_count_r != 8'hFF)) begin
            err_count_r <= err_count_r + 8'd1;
        end else begin
            err_count_r <= err_count_r;
        end
    end

endmodule : ahb_fabric_dp
